i2c_eeprom_slave: RTL

//  I2C responder that emulates a 24Cxx-style EEPROM on the bus driven by the team's I2C master.

---
 rtl/i2c_eeprom_slave.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_eeprom_slave.sv
// 24Cxx-style I2C EEPROM responder: oversamples SCL/SDA, detects START/STOP and serves
// byte/sequential writes and random/sequential reads from an internal byte array.
module i2c_eeprom_slave #(
    parameter logic [6:0]  DEVICE_ADDR = 7'b1010_111,
    parameter logic        ADDR_NUM    = 1'b1,
    parameter int unsigned MEM_AW      = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    output logic        busy,
    output logic        wr_pulse,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data
);
    localparam int unsigned DEPTH = 2 ** MEM_AW;
    localparam int unsigned PTR_W = 16;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, ACK_DEV, ADDR_H, ACK_AH, ADDR_L, ACK_AL,
        WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_P
    } state_e;

    logic [1:0]       scl_sync_q, sda_sync_q;
    logic             scl_hist_q, sda_hist_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       addr_h_q, addr_h_d;
    logic             rw_q, rw_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             wr_pulse_q, wr_pulse_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [7:0]       mem [DEPTH];

    logic scl_c, sda_c, scl_rise_c, scl_fall_c, start_c, stop_c;
    logic [7:0] rd_byte_c;

    // Input synchronizers; idle-bus reset values avoid spurious edges after reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i2c_scl};
            sda_sync_q <= {sda_sync_q[0], i2c_sda};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    assign scl_c      = scl_sync_q[1];
    assign sda_c      = sda_sync_q[1];
    assign scl_rise_c = scl_c & ~scl_hist_q;
    assign scl_fall_c = ~scl_c & scl_hist_q;
    assign start_c    = scl_c & scl_hist_q & sda_hist_q & ~sda_c;
    assign stop_c     = scl_c & scl_hist_q & ~sda_hist_q & sda_c;
    assign rd_byte_c  = mem[ptr_q[MEM_AW-1:0]];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            addr_h_q   <= '0;
            rw_q       <= 1'b0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            addr_h_q   <= addr_h_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Memory is committed one cycle after the pulse from the registered write port.
    always_ff @(posedge sys_clk) begin
        if (wr_pulse_q) begin
            mem[wr_addr_q[MEM_AW-1:0]] <= wr_data_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        addr_h_d   = addr_h_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            DEV_ADDR, ADDR_H, ADDR_L, WR_DATA: begin
                if (scl_rise_c) begin
                    shift_d = {shift_q[6:0], sda_c};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (state_q == WR_DATA && cnt_q == CNT_W'(7)) begin
                        wr_pulse_d = 1'b1;
                        wr_addr_d  = ptr_q;
                        wr_data_d  = {shift_q[6:0], sda_c};
                    end
                end else if (scl_fall_c && cnt_q == CNT_W'(8)) begin
                    cnt_d    = '0;
                    sda_oe_d = 1'b1;
                    case (state_q)
                        DEV_ADDR: begin
                            if (shift_q[7:1] == DEVICE_ADDR) begin
                                state_d = ACK_DEV;
                                rw_d    = shift_q[0];
                            end else begin
                                state_d  = WAIT_P;
                                sda_oe_d = 1'b0;
                            end
                        end
                        ADDR_H: begin
                            state_d  = ACK_AH;
                            addr_h_d = shift_q;
                        end
                        ADDR_L:  state_d = ACK_AL;
                        default: begin
                            state_d = ACK_WR;
                            ptr_d   = ptr_q + PTR_W'(1);
                        end
                    endcase
                end
            end
            ACK_DEV: begin
                if (scl_fall_c) begin
                    sda_oe_d = 1'b0;
                    cnt_d    = '0;
                    if (rw_q) begin
                        state_d  = RD_DATA;
                        shift_d  = rd_byte_c;
                        sda_oe_d = ~rd_byte_c[7];
                    end else begin
                        state_d = ADDR_NUM ? ADDR_H : ADDR_L;
                    end
                end
            end
            ACK_AH: begin
                if (scl_fall_c) begin
                    state_d  = ADDR_L;
                    sda_oe_d = 1'b0;
                end
            end
            ACK_AL: begin
                if (scl_fall_c) begin
                    state_d  = WR_DATA;
                    sda_oe_d = 1'b0;
                    ptr_d    = ADDR_NUM ? {addr_h_q, shift_q} : {8'h00, shift_q};
                end
            end
            ACK_WR: begin
                if (scl_fall_c) begin
                    state_d  = WR_DATA;
                    sda_oe_d = 1'b0;
                end
            end
            RD_DATA: begin
                if (scl_rise_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (scl_fall_c) begin
                    if (cnt_q == CNT_W'(8)) begin
                        state_d  = RD_ACK;
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
            end
            RD_ACK: begin
                // cnt_q marks a seen ACK so the next byte loads on the following fall
                if (scl_rise_c) begin
                    ptr_d = ptr_q + PTR_W'(1);
                    if (sda_c) begin
                        state_d = WAIT_P;
                    end else begin
                        cnt_d = CNT_W'(1);
                    end
                end else if (scl_fall_c && cnt_q == CNT_W'(1)) begin
                    state_d  = RD_DATA;
                    cnt_d    = '0;
                    shift_d  = rd_byte_c;
                    sda_oe_d = ~rd_byte_c[7];
                end
            end
            default: ;
        endcase

        // Bus conditions override every state and abort any partial byte.
        if (start_c) begin
            state_d    = DEV_ADDR;
            cnt_d      = '0;
            busy_d     = 1'b1;
            sda_oe_d   = 1'b0;
            wr_pulse_d = 1'b0;
        end else if (stop_c) begin
            state_d    = IDLE;
            cnt_d      = '0;
            busy_d     = 1'b0;
            sda_oe_d   = 1'b0;
            wr_pulse_d = 1'b0;
        end
    end

    assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
    assign busy     = busy_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule
